// File: rtl/ofifo.sv
// Output FIFO collecting psums from the array south edge: one lane per column,
// independent per-lane writes, aligned all-lane pops. Optional sticky o_err via OFIFO_ERR_EN.
module ofifo #(
    parameter int unsigned col   = 8,
    parameter int unsigned bw    = 16,
    parameter int unsigned depth = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_valid
`ifdef OFIFO_ERR_EN
    ,
    output logic              o_err
`endif
);

    localparam int unsigned aw    = $clog2(depth);
    localparam int unsigned ptr_w = aw + 1;

    logic [col-1:0] lane_full;
    logic [col-1:0] lane_empty;
    logic [col-1:0] wr_go;
    logic           rd_go;

    // Flags are purely combinational from the pointers.
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign o_valid = ~|lane_empty;
    assign rd_go   = rd & o_valid;

    for (genvar i = 0; i < int'(col); i++) begin : g_lane
        logic [bw-1:0]    mem [depth];
        logic [ptr_w-1:0] wr_ptr;
        logic [ptr_w-1:0] rd_ptr;

        // Same index with differing wrap bits means the writer lapped the reader.
        assign lane_empty[i] = (wr_ptr == rd_ptr);
        assign lane_full[i]  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) &&
                               (wr_ptr[aw] != rd_ptr[aw]);
        assign wr_go[i]      = wr[i] & ~lane_full[i];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_go[i]) wr_ptr <= wr_ptr + ptr_w'(1);
                if (rd_go)    rd_ptr <= rd_ptr + ptr_w'(1);
            end
        end

        // Storage is never cleared; only the pointers define what is valid.
        always_ff @(posedge clk) begin
            if (!reset && wr_go[i]) mem[wr_ptr[aw-1:0]] <= in[bw*i +: bw];
        end

        // First-word-fall-through head, masked to zero until every lane has data.
        assign out[bw*i +: bw] = o_valid ? mem[rd_ptr[aw-1:0]] : '0;
    end

`ifdef OFIFO_ERR_EN
    logic err_set;

    assign err_set = (|(wr & lane_full)) | (rd & ~o_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        o_err <= 1'b0;
        else if (err_set) o_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo: randomized traffic against a per-lane write-log reference model.
module tb_ofifo;

    localparam int unsigned COL   = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LOGN  = 4096;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [COL*BW-1:0]   in = '0;
    logic [COL-1:0]      wr = '0;
    logic                rd = 1'b0;
    logic [COL*BW-1:0]   out;
    logic                o_full;
    logic                o_ready;
    logic                o_valid;
`ifdef OFIFO_ERR_EN
    logic                o_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference: every accepted write is appended to its lane's log; pops advance a shared read count.
    logic [BW-1:0] mlist [COL][LOGN];
    int            mw [COL];
    int            mr;
    logic          m_err;

    ofifo #(.col(COL), .bw(BW), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_valid (o_valid)
`ifdef OFIFO_ERR_EN
        ,
        .o_err   (o_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic m_valid();
        logic v = 1'b1;
        for (int i = 0; i < int'(COL); i++) if (mw[i] - mr == 0) v = 1'b0;
        return v;
    endfunction

    function automatic logic m_full();
        logic f = 1'b0;
        for (int i = 0; i < int'(COL); i++) if (mw[i] - mr == int'(DEPTH)) f = 1'b1;
        return f;
    endfunction

    function automatic logic [COL*BW-1:0] m_out();
        logic [COL*BW-1:0] r = '0;
        if (m_valid())
            for (int i = 0; i < int'(COL); i++) r[BW*i +: BW] = mlist[i][mr % int'(LOGN)];
        return r;
    endfunction

    function automatic logic [COL*BW-1:0] rand_vec();
        logic [COL*BW-1:0] r;
        for (int i = 0; i < int'(COL); i++) r[BW*i +: BW] = BW'($urandom);
        return r;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < int'(COL); i++) mw[i] = 0;
        mr    = 0;
        m_err = 1'b0;
    endtask

    // One clock: drive at negedge, update model at posedge, return at next negedge.
    task automatic cyc(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
        logic           v;
        logic [COL-1:0] f;
        wr = w; in = d; rd = r;
        v = m_valid();
        for (int i = 0; i < int'(COL); i++) f[i] = (mw[i] - mr == int'(DEPTH));
        @(posedge clk);
        if (r && !v) m_err = 1'b1;
        if (|(w & f)) m_err = 1'b1;
        if (r && v) mr++;
        for (int i = 0; i < int'(COL); i++)
            if (w[i] && !f[i]) begin
                mlist[i][mw[i] % int'(LOGN)] = d[BW*i +: BW];
                mw[i]++;
            end
        @(negedge clk);
        wr = '0; rd = 1'b0;
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_clear();
    endtask

    task automatic test_reset();
        m_clear();
        #12;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out); end
`ifdef OFIFO_ERR_EN
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", o_err); end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_staggered();
        logic [COL*BW-1:0] d;
        for (int i = 0; i < int'(COL); i++) d[BW*i +: BW] = BW'(16'h0100 + i);
        for (int i = 0; i < int'(COL); i++) begin
            cyc(COL'(1) << i, d, 1'b0);
            checks++;
            if (o_valid !== (i == int'(COL) - 1)) begin
                errors++; $display("FAIL stagger_valid lane %0d got %b exp %b", i, o_valid, i == int'(COL) - 1);
            end
        end
        checks++; if (out !== d) begin errors++; $display("FAIL stagger_out got %h exp %h", out, d); end
        cyc('0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stagger_pop_valid got %b exp 0", o_valid); end
        checks++; if (out !== '0) begin errors++; $display("FAIL stagger_pop_out got %h exp 0", out); end
    endtask

    task automatic test_fill();
        logic [COL*BW-1:0] dead;
        logic              seen_dead = 1'b0;
        for (int i = 0; i < int'(COL); i++) dead[BW*i +: BW] = 16'hDEAD;
        for (int k = 0; k < int'(DEPTH); k++) begin
            logic [COL*BW-1:0] d = rand_vec();
            for (int i = 0; i < int'(COL); i++) if (d[BW*i +: BW] == 16'hDEAD) d[BW*i +: BW] = 16'h0000;
            cyc('1, d, 1'b0);
        end
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", o_full); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", o_ready); end
        cyc('1, dead, 1'b0);
        checks++; if (o_full !== m_full()) begin errors++; $display("FAIL fill_drop_full got %b exp %b", o_full, m_full()); end
        for (int k = 0; k < int'(DEPTH); k++) begin
            checks++;
            if (out !== m_out()) begin errors++; $display("FAIL fill_read %0d got %h exp %h", k, out, m_out()); end
            for (int i = 0; i < int'(COL); i++) if (out[BW*i +: BW] == 16'hDEAD) seen_dead = 1'b1;
            cyc('0, '0, 1'b1);
        end
        checks++; if (seen_dead !== 1'b0) begin errors++; $display("FAIL fill_dead_seen got %b exp 0", seen_dead); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fill_end_valid got %b exp 0", o_valid); end
    endtask

    task automatic test_stream();
        int bad = 0;
        cyc('1, rand_vec(), 1'b0);
        for (int k = 0; k < 200; k++) begin
            cyc('1, rand_vec(), 1'b1);
            if (o_valid !== 1'b1 || out !== m_out() || (mw[0] - mr) != 1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stream_cycles got %0d bad exp 0", bad); end
        checks++; if (out !== m_out()) begin errors++; $display("FAIL stream_out got %h exp %h", out, m_out()); end
    endtask

    task automatic test_partial_rd();
        for (int k = 0; k < 80 && m_valid(); k++) cyc('0, '0, 1'b1);
        cyc(8'hF7, rand_vec(), 1'b0);
        cyc(8'hF7, rand_vec(), 1'b0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL partial_valid got %b exp 0", o_valid); end
        cyc('0, '0, 1'b1);
        checks++; if (out !== '0) begin errors++; $display("FAIL partial_rd_out got %h exp 0", out); end
        cyc(8'h08, rand_vec(), 1'b0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL partial_lane3_valid got %b exp 1", o_valid); end
        checks++; if (out !== m_out()) begin errors++; $display("FAIL partial_lane3_out got %h exp %h", out, m_out()); end
        cyc('0, '0, 1'b1);
        checks++; if (o_valid !== m_valid()) begin errors++; $display("FAIL partial_pop_valid got %b exp %b", o_valid, m_valid()); end
        checks++; if (out !== m_out()) begin errors++; $display("FAIL partial_pop_out got %h exp %h", out, m_out()); end
    endtask

    task automatic test_async_reset();
        logic [COL*BW-1:0] d;
        for (int k = 0; k < 10; k++) cyc('1, rand_vec(), 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", o_valid); end
        checks++; if (out !== '0) begin errors++; $display("FAIL async_out got %h exp 0", out); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL async_ready got %b exp 1", o_ready); end
        @(negedge clk);
        reset = 1'b0;
        m_clear();
        d = rand_vec();
        cyc('1, d, 1'b0);
        checks++; if (out !== d) begin errors++; $display("FAIL async_new_out got %h exp %h", out, d); end
        cyc('0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_new_valid got %b exp 0", o_valid); end
    endtask

    task automatic test_err();
        sync_reset();
        cyc('0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0 || out !== '0) begin errors++; $display("FAIL err_idle_rd got %b/%h exp 0/0", o_valid, out); end
`ifdef OFIFO_ERR_EN
        checks++; if (o_err !== m_err) begin errors++; $display("FAIL err_rd_set got %b exp %b", o_err, m_err); end
`endif
        for (int k = 0; k < 3; k++) cyc('1, rand_vec(), 1'b1);
        checks++; if (out !== m_out()) begin errors++; $display("FAIL err_legal_out got %h exp %h", out, m_out()); end
`ifdef OFIFO_ERR_EN
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_hold got %b exp 1", o_err); end
`endif
        sync_reset();
`ifdef OFIFO_ERR_EN
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", o_err); end
`endif
        for (int k = 0; k < int'(DEPTH); k++) cyc(8'h01, rand_vec(), 1'b0);
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL err_lane0_full got %b exp 1", o_full); end
        cyc(8'h03, rand_vec(), 1'b0);
        checks++; if (o_full !== m_full() || o_valid !== m_valid()) begin
            errors++; $display("FAIL err_drop_flags got %b/%b exp %b/%b", o_full, o_valid, m_full(), m_valid());
        end
`ifdef OFIFO_ERR_EN
        checks++; if (o_err !== m_err) begin errors++; $display("FAIL err_wr_set got %b exp %b", o_err, m_err); end
`endif
        sync_reset();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 400; k++) begin
            logic [COL-1:0] w = ($urandom_range(0, 1) == 0) ? COL'('1) : COL'($urandom);
            logic           r = ($urandom_range(0, 2) == 0);
            cyc(w, rand_vec(), r);
            if (out !== m_out() || o_valid !== m_valid() || o_full !== m_full() || o_ready !== !m_full()) begin
                bad++;
                if (bad < 4) $display("FAIL random cyc %0d got %h v%b f%b exp %h v%b f%b",
                                      k, out, o_valid, o_full, m_out(), m_valid(), m_full());
            end
`ifdef OFIFO_ERR_EN
            if (o_err !== m_err) bad++;
`endif
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL random_total got %0d bad exp 0", bad); end
    endtask

    initial begin
        test_reset();
        test_staggered();
        test_fill();
        test_stream();
        test_partial_rd();
        test_async_reset();
        test_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
